// File: rtl/glb_bank_sram_arbiter.sv
// glb_bank_sram_arbiter
//
// Shares one GLB bank SRAM between two requesters. Port 0 is the
// processor/config side and port 1 is the stream/DMA side. At most one
// access is granted per cycle. The SRAM pin drive is registered, and read
// data coming back from the SRAM is routed to the port that issued the
// read, in issue order.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   cfg_fixed_prio      0 = round-robin on contention, 1 = port 0 always wins
//   pN_req_valid/ready  request handshake (ready is the combinational grant)
//   pN_req_wr_en        1 = write, 0 = read
//   pN_req_addr/data    word address / write data
//   pN_req_strb         active-high write byte enables
//   pN_rd_valid/data    read response (no backpressure)
//   sram_ceb/web        active-low chip / write enable (registered)
//   sram_addr/d         SRAM address / write data (held while idle)
//   sram_bweb           active-low bit write enable
//   sram_q              SRAM read data, valid SRAM_RD_LATENCY cycles after the pins

module glb_bank_sram_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 14,
  parameter int SRAM_RD_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_fixed_prio,

  input  logic                    p0_req_valid,
  output logic                    p0_req_ready,
  input  logic                    p0_req_wr_en,
  input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
  input  logic [DATA_WIDTH-1:0]   p0_req_data,
  input  logic [DATA_WIDTH/8-1:0] p0_req_strb,
  output logic                    p0_rd_valid,
  output logic [DATA_WIDTH-1:0]   p0_rd_data,

  input  logic                    p1_req_valid,
  output logic                    p1_req_ready,
  input  logic                    p1_req_wr_en,
  input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
  input  logic [DATA_WIDTH-1:0]   p1_req_data,
  input  logic [DATA_WIDTH/8-1:0] p1_req_strb,
  output logic                    p1_rd_valid,
  output logic [DATA_WIDTH-1:0]   p1_rd_data,

  output logic                    sram_ceb,
  output logic                    sram_web,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_bweb,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  // One stage for the registered pin drive plus the SRAM's own latency.
  localparam int TRACK_DEPTH = SRAM_RD_LATENCY + 1;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e                   last_p;
  logic                    contended;
  logic                    grant0;
  logic                    grant1;
  logic                    any_grant;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [STRB_WIDTH-1:0]   sel_strb;
  logic [DATA_WIDTH-1:0]   wr_bweb;
  logic                    rd_issue;
  logic [TRACK_DEPTH-1:0]  trk_valid;
  logic [TRACK_DEPTH-1:0]  trk_port;
  logic                    ret_valid;

  // Grant logic. last_p records the winner of the most recent contended
  // cycle, so round-robin gives the other port the win. Uncontended grants
  // leave last_p alone. Holding both grants low during reset keeps the
  // ready outputs at 0 while reset is asserted.
  always_comb begin
    contended = p0_req_valid && p1_req_valid;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (!reset) begin
      if (contended) begin
        if (cfg_fixed_prio || (last_p == PORT1)) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = p0_req_valid;
        grant1 = p1_req_valid;
      end
    end
  end

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign any_grant    = grant0 || grant1;

  // Select the granted request's fields and expand the byte strobes into
  // active-low bit enables.
  always_comb begin
    sel_wr   = grant1 ? p1_req_wr_en : p0_req_wr_en;
    sel_addr = grant1 ? p1_req_addr  : p0_req_addr;
    sel_data = grant1 ? p1_req_data  : p0_req_data;
    sel_strb = grant1 ? p1_req_strb  : p0_req_strb;
    wr_bweb  = '1;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      wr_bweb[8*b +: 8] = {8{~sel_strb[b]}};
    end
  end

  assign rd_issue = any_grant && !sel_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_p    <= PORT1;
      sram_ceb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_bweb <= '1;
      sram_addr <= '0;
      sram_d    <= '0;
      trk_valid <= '0;
      trk_port  <= '0;
    end else begin
      if (contended) begin
        last_p <= grant1 ? PORT1 : PORT0;
      end
      // The tracking pipe mirrors the SRAM pipeline. Entry 0 lines up with
      // the registered pin drive, and the last entry lines up with sram_q.
      trk_valid <= {trk_valid[TRACK_DEPTH-2:0], rd_issue};
      trk_port  <= {trk_port[TRACK_DEPTH-2:0], grant1};
      if (any_grant) begin
        sram_ceb  <= 1'b0;
        sram_web  <= ~sel_wr;
        sram_addr <= sel_addr;
        if (sel_wr) begin
          sram_bweb <= wr_bweb;
          sram_d    <= sel_data;
        end else begin
          sram_bweb <= '1;
        end
      end else begin
        // The address and data buses hold their values to avoid needless
        // toggling on the macro pins.
        sram_ceb  <= 1'b1;
        sram_web  <= 1'b1;
        sram_bweb <= '1;
      end
    end
  end

  // Gating with reset drops a response that would otherwise land during a
  // reset cycle, before the tracking pipe is cleared.
  assign ret_valid   = trk_valid[TRACK_DEPTH-1] && !reset;
  assign p0_rd_valid = ret_valid && !trk_port[TRACK_DEPTH-1];
  assign p1_rd_valid = ret_valid &&  trk_port[TRACK_DEPTH-1];
  assign p0_rd_data  = p0_rd_valid ? sram_q : '0;
  assign p1_rd_data  = p1_rd_valid ? sram_q : '0;

endmodule

// File: tb/tb_glb_bank_sram_arbiter.sv
// tb_glb_bank_sram_arbiter
//
// Drives glb_bank_sram_arbiter with directed and random requests, together
// with a behavioural SRAM macro model. The expected grants, pin drive and
// read responses come from a transaction-level reference model. A separate
// monitor compares those expectations against the DUT outputs.

module tb_glb_bank_sram_arbiter;

  localparam int DW  = 64;
  localparam int AW  = 14;
  localparam int LAT = 3;
  localparam int SW  = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_fixed_prio;
  logic          p0_req_valid, p0_req_ready, p0_req_wr_en;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_data;
  logic [SW-1:0] p0_req_strb;
  logic          p0_rd_valid;
  logic [DW-1:0] p0_rd_data;
  logic          p1_req_valid, p1_req_ready, p1_req_wr_en;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_data;
  logic [SW-1:0] p1_req_strb;
  logic          p1_rd_valid;
  logic [DW-1:0] p1_rd_data;
  logic          sram_ceb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_bweb, sram_d;
  logic [DW-1:0] sram_q = '0;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  typedef struct {
    bit          v;
    bit          wr;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
    bit [SW-1:0] strb;
  } req_t;

  typedef struct {
    int          due;
    bit          port;
    bit [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int          due;
    bit          ceb;
    bit          web;
    bit [AW-1:0] addr;
    bit [DW-1:0] bweb;
    bit [DW-1:0] d;
  } pin_exp_t;

  rd_exp_t  rd_q[$];
  pin_exp_t pin_q[$];

  // Reference model state.
  bit [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit          mdl_last_winner = 1'b1;
  bit [AW-1:0] mdl_addr = '0;
  bit [DW-1:0] mdl_d = '0;

  // Behavioural SRAM macro: two input register stages, then the array read.
  bit [DW-1:0] sram_mem [0:(1<<AW)-1];
  bit [DW-1:0] q_stage0, q_stage1;

  glb_bank_sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .cfg_fixed_prio(cfg_fixed_prio),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wr_en(p0_req_wr_en),
    .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data), .p0_req_strb(p0_req_strb),
    .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wr_en(p1_req_wr_en),
    .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data), .p1_req_strb(p1_req_strb),
    .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_bweb(sram_bweb), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    bit [DW-1:0] rdata;
    rdata = '0;
    if (sram_ceb === 1'b0) begin
      if (sram_web === 1'b0) begin
        sram_mem[sram_addr] = (sram_mem[sram_addr] & sram_bweb) | (sram_d & ~sram_bweb);
      end else begin
        rdata = sram_mem[sram_addr];
      end
    end
    q_stage0 <= rdata;
    q_stage1 <= q_stage0;
    sram_q   <= q_stage1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mkReq(bit v, bit wr, bit [AW-1:0] addr, bit [DW-1:0] data, bit [SW-1:0] strb);
    req_t r;
    r.v = v; r.wr = wr; r.addr = addr; r.data = data; r.strb = strb;
    return r;
  endfunction

  function automatic bit [DW-1:0] strbMask(bit [SW-1:0] strb);
    bit [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) if (strb[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // Presents one cycle of inputs, then predicts the grant from the
  // arbitration rules, checks ready, and queues the expected pin drive and
  // read response.
  task automatic applyStimulus(input bit rst, input bit fixed, input req_t r0, input req_t r1,
                               output bit g0, output bit g1);
    req_t     r;
    pin_exp_t pe;
    rd_exp_t  re;
    bit [DW-1:0] m;
    @(posedge clk);
    #1;
    reset = rst; cfg_fixed_prio = fixed;
    p0_req_valid = r0.v; p0_req_wr_en = r0.wr; p0_req_addr = r0.addr; p0_req_data = r0.data; p0_req_strb = r0.strb;
    p1_req_valid = r1.v; p1_req_wr_en = r1.wr; p1_req_addr = r1.addr; p1_req_data = r1.data; p1_req_strb = r1.strb;
    @(negedge clk);
    if (rst) begin
      g0 = 1'b0; g1 = 1'b0;
      mdl_last_winner = 1'b1;
    end else if (r0.v && r1.v) begin
      if (fixed || mdl_last_winner) begin g0 = 1'b1; g1 = 1'b0; end
      else begin g0 = 1'b0; g1 = 1'b1; end
      mdl_last_winner = g1;
    end else begin
      g0 = r0.v; g1 = r1.v;
    end
    checkOutput("p0_req_ready", {63'd0, p0_req_ready}, {63'd0, g0});
    checkOutput("p1_req_ready", {63'd0, p1_req_ready}, {63'd0, g1});
    pe.due = cyc + 1; pe.ceb = 1'b1; pe.web = 1'b1; pe.bweb = '1;
    if (rst) begin
      mdl_addr = '0; mdl_d = '0;
    end else if (g0 || g1) begin
      r = g1 ? r1 : r0;
      pe.ceb = 1'b0;
      mdl_addr = r.addr;
      if (r.wr) begin
        m = strbMask(r.strb);
        ref_mem[r.addr] = (ref_mem[r.addr] & ~m) | (r.data & m);
        pe.web = 1'b0; pe.bweb = ~m; mdl_d = r.data;
      end else begin
        re.due = cyc + 1 + LAT; re.port = g1; re.data = ref_mem[r.addr];
        rd_q.push_back(re);
      end
    end
    pe.addr = mdl_addr; pe.d = mdl_d;
    pin_q.push_back(pe);
  endtask

  // Monitor: pops the expected pin drive and read responses due in this cycle.
  always @(negedge clk) begin
    pin_exp_t pe;
    rd_exp_t  re;
    if (pin_q.size() > 0 && pin_q[0].due == cyc) begin
      pe = pin_q.pop_front();
      checkOutput("sram_ceb",  {63'd0, sram_ceb}, {63'd0, pe.ceb});
      checkOutput("sram_web",  {63'd0, sram_web}, {63'd0, pe.web});
      checkOutput("sram_addr", {50'd0, sram_addr}, {50'd0, pe.addr});
      checkOutput("sram_bweb", sram_bweb, pe.bweb);
      checkOutput("sram_d",    sram_d, pe.d);
    end
    if (reset === 1'b1) begin
      rd_q.delete();
      checkOutput("p0_rd_valid_in_reset", {63'd0, p0_rd_valid}, 64'd0);
      checkOutput("p1_rd_valid_in_reset", {63'd0, p1_rd_valid}, 64'd0);
    end else if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      re = rd_q.pop_front();
      checkOutput("p0_rd_valid", {63'd0, p0_rd_valid}, {63'd0, !re.port});
      checkOutput("p1_rd_valid", {63'd0, p1_rd_valid}, {63'd0, re.port});
      checkOutput("p0_rd_data", p0_rd_data, re.port ? 64'd0 : re.data);
      checkOutput("p1_rd_data", p1_rd_data, re.port ? re.data : 64'd0);
    end else begin
      checkOutput("p0_rd_valid_idle", {63'd0, p0_rd_valid}, 64'd0);
      checkOutput("p1_rd_valid_idle", {63'd0, p1_rd_valid}, 64'd0);
      checkOutput("p0_rd_data_idle", p0_rd_data, 64'd0);
      checkOutput("p1_rd_data_idle", p1_rd_data, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_t idle, a, b;
    bit   g0, g1, fixed;
    idle = mkReq(0, 0, '0, '0, '0);
    reset = 1'b1; cfg_fixed_prio = 1'b0;
    p0_req_valid = 0; p0_req_wr_en = 0; p0_req_addr = '0; p0_req_data = '0; p0_req_strb = '0;
    p1_req_valid = 0; p1_req_wr_en = 0; p1_req_addr = '0; p1_req_data = '0; p1_req_strb = '0;

    // Reset, with valid requests present in one of the reset cycles.
    applyStimulus(1, 0, idle, idle, g0, g1);
    applyStimulus(1, 0, mkReq(1, 0, 14'h5, '0, '0), mkReq(1, 0, 14'h6, '0, '0), g0, g1);
    applyStimulus(1, 0, idle, idle, g0, g1);

    // Single read after a preload write.
    applyStimulus(0, 0, mkReq(1, 1, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF), idle, g0, g1);
    applyStimulus(0, 0, idle, idle, g0, g1);
    applyStimulus(0, 0, mkReq(1, 0, 14'h0123, '0, '0), idle, g0, g1);
    repeat (5) applyStimulus(0, 0, idle, idle, g0, g1);

    // Byte strobe: full write, then a write of 0 with strb 0x0F, then readback.
    applyStimulus(0, 0, mkReq(1, 1, 14'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF), idle, g0, g1);
    applyStimulus(0, 0, mkReq(1, 1, 14'h10, 64'h0, 8'h0F), idle, g0, g1);
    applyStimulus(0, 0, idle, mkReq(1, 1, 14'h10, 64'h1234, 8'h00), g0, g1);
    applyStimulus(0, 0, idle, mkReq(1, 0, 14'h10, '0, '0), g0, g1);

    // Preload the round-robin addresses.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, mkReq(1, 1, 14'h100 + 14'(k), {$urandom, $urandom}, 8'hFF), idle, g0, g1);
      applyStimulus(0, 0, idle, mkReq(1, 1, 14'h200 + 14'(k), {$urandom, $urandom}, 8'hFF), g0, g1);
    end

    // Contended reads under round-robin, then under fixed priority.
    for (int pass = 0; pass < 2; pass++) begin
      int i0, i1;
      i0 = 0; i1 = 0;
      a = mkReq(1, 0, 14'h100, '0, '0);
      b = mkReq(1, 0, 14'h200, '0, '0);
      for (int k = 0; k < 6; k++) begin
        applyStimulus(0, bit'(pass), a, b, g0, g1);
        if (g0) begin i0++; a.addr = 14'h100 + 14'(i0 % 8); end
        if (g1) begin i1++; b.addr = 14'h200 + 14'(i1 % 8); end
      end
      if (pass == 1) applyStimulus(0, 1, idle, b, g0, g1);
      repeat (5) applyStimulus(0, 0, idle, idle, g0, g1);
    end

    // Write on port 1 followed immediately by a read on port 0.
    applyStimulus(0, 0, idle, mkReq(1, 1, 14'h3FFF, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF), g0, g1);
    applyStimulus(0, 0, mkReq(1, 0, 14'h3FFF, '0, '0), idle, g0, g1);
    repeat (5) applyStimulus(0, 0, idle, idle, g0, g1);

    // Reset while three reads are in flight; a request in the first cycle
    // after reset must be granted.
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, mkReq(1, 0, 14'h100 + 14'(k), '0, '0), idle, g0, g1);
    repeat (1) applyStimulus(0, 0, idle, idle, g0, g1);
    applyStimulus(1, 0, idle, idle, g0, g1);
    applyStimulus(1, 0, idle, idle, g0, g1);
    applyStimulus(0, 0, idle, mkReq(1, 0, 14'h3FFF, '0, '0), g0, g1);
    repeat (6) applyStimulus(0, 0, idle, idle, g0, g1);

    // Random traffic with held requests and occasional priority changes.
    a = idle; b = idle; fixed = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!a.v && ($urandom_range(0, 3) != 0))
        a = mkReq(1, bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15)),
                  {$urandom, $urandom}, 8'($urandom));
      if (!b.v && ($urandom_range(0, 3) != 0))
        b = mkReq(1, bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15)),
                  {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(0, 7) == 0) fixed = ~fixed;
      applyStimulus((k == 200) || (k == 201), fixed, a, b, g0, g1);
      if (g0) a = idle;
      if (g1) b = idle;
    end
    repeat (8) applyStimulus(0, 0, idle, idle, g0, g1);
    checkOutput("rd_queue_drained", 64'(rd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/glb_bank_sram_arbiter.md
Name: glb_bank_sram_arbiter

Overview:
- Shares one bank SRAM between two requesters: port 0 (processor/config side) and port 1 (stream/DMA side).
- The SRAM is the 2048x64-macro-based bank memory. It has a 2-stage input pipeline and 1-cycle macro read, so read data appears 3 cycles after its pins are driven.
- The arbiter grants at most one access per cycle, registers the SRAM pin drive, and routes returning read data to the issuing port in order.
- It sits in the GLB bank between the bank's port muxes and the SRAM generator.

Parameters:
- DATA_WIDTH, 64, data word width; must be a multiple of 8.
- ADDR_WIDTH, 14, word address width (16K words).
- SRAM_RD_LATENCY, 3, cycles from SRAM pins driven to valid sram_q.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cfg_fixed_prio  in  1  0 = round-robin; 1 = port 0 always wins
- p0_req_valid  in  1  port 0 request valid
- p0_req_ready  out  1  port 0 granted this cycle (combinational)
- p0_req_wr_en  in  1  1 = write, 0 = read
- p0_req_addr  in  ADDR_WIDTH  word address
- p0_req_data  in  DATA_WIDTH  write data
- p0_req_strb  in  DATA_WIDTH/8  write byte enables, active-high
- p0_rd_valid  out  1  port 0 read data valid
- p0_rd_data  out  DATA_WIDTH  port 0 read data
- p1_* : same set as p0_*, for port 1
- sram_ceb  out  1  SRAM chip enable, active-low
- sram_web  out  1  SRAM write enable, active-low
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_bweb  out  DATA_WIDTH  bit write enable, active-low
- sram_d  out  DATA_WIDTH  SRAM write data
- sram_q  in  DATA_WIDTH  SRAM read data

Behaviour:
- Handshake
  - A transfer occurs in cycle t when req_valid && req_ready.
  - req_ready depends only on the valid inputs, cfg_fixed_prio and the arbiter state; it never depends on ready.
  - Requesters must hold addr/data/wr_en/strb stable while valid && !ready.
- Arbitration
  - Only one valid: that port is granted.
  - Both valid, cfg_fixed_prio=1: grant port 0.
  - Both valid, cfg_fixed_prio=0: grant the port not granted in the most recent contended cycle.
  - Pointer last_p updates only on contended cycles, so an uncontended grant does not change fairness.
  - Reset state is last_p=1, so port 0 wins the first contention.
  - cfg_fixed_prio may change any cycle; it takes effect the same cycle.
- SRAM drive, registered, all valid in cycle t+1
  - Read: sram_ceb=0, sram_web=1, sram_bweb=all 1, sram_addr=addr.
  - Write: sram_ceb=0, sram_web=0, sram_addr=addr, sram_d=data.
  - Write bweb: sram_bweb[8b+7:8b] = {8{~strb[b]}}.
  - A write with strb=0 is still issued (CEB low) and modifies no bits.
  - Idle cycle: sram_ceb=1, sram_web=1, sram_bweb=all 1; addr and d hold their previous value.
- Read return
  - A read handshaked in cycle t returns rd_valid=1 for one cycle, t+1+SRAM_RD_LATENCY (t+4 at default).
  - rd_data = sram_q, combinational, for the tagged port only.
  - Tracking: a (SRAM_RD_LATENCY+1)-deep shift register of {valid, port}.
  - Returns are strictly in issue order. Back-to-back reads give back-to-back rd_valid.
  - No response backpressure; consumers must accept.
  - The non-selected port's rd_data is 0.
- Writes produce no response.
- Ordering
  - A read of an address written in an earlier cycle returns the new data, because the SRAM pipeline keeps order.
  - Same-cycle requests from both ports to one address are serialized by arbitration order.
- Reset values
  - Outputs: sram_ceb=1, sram_web=1, sram_bweb=all 1, sram_addr=0, sram_d=0, p*_rd_valid=0, p*_rd_data=0.
  - During reset: p*_req_ready=0.
  - State: last_p=1; tracking shift register all invalid.
- Reset mid-operation
  - In-flight reads are dropped and no rd_valid is generated for them.
  - The first grant is possible in the cycle after reset deasserts.
- Throughput: 1 access per cycle, sustained, with no bubbles between ports.

Test Plan:
- Single read: preload addr 0x0123=0xDEADBEEF_CAFEF00D via port 0 write, idle, then port 0 read of 0x0123 at cycle t -> p0_rd_valid=1 only at t+4 with data 0xDEADBEEF_CAFEF00D; p1_rd_valid stays 0.
- Byte strobe: write 0xFFFF_FFFF_FFFF_FFFF to 0x10, then write 0 with strb=0x0F -> sram_bweb=0xFFFF_FFFF_0000_0000 on the second write; readback = 0xFFFF_FFFF_0000_0000.
- Round-robin: both ports hold valid reads for 6 cycles, cfg_fixed_prio=0 -> grants alternate 0,1,0,1,0,1; rd_valid returns alternate per port 4 cycles later, each with correct data.
- Fixed priority: same stimulus with cfg_fixed_prio=1 -> port 0 granted for 6 cycles and p1_req_ready=0 throughout; drop p0 valid -> port 1 granted the next cycle.
- Write-then-read, different ports: p1 writes 0xA5A5_A5A5_A5A5_A5A5 to 0x3FFF at cycle t, p0 reads 0x3FFF at t+1 -> p0_rd_data=0xA5A5_A5A5_A5A5_A5A5 at t+5.
- Reset mid-flight: issue 3 back-to-back reads, assert reset 2 cycles after the last -> no rd_valid afterwards; sram_ceb=1 during reset; first new grant occurs the cycle after reset deasserts.
